// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan path (scan controller and decoder).
package seg_pkg;

    localparam int NUM_DIGITS          = 8;
    localparam int REFRESH_DIV_DEFAULT = 100000;

    typedef logic [3:0] digit_t;
    typedef logic [2:0] sel_t;

    // Next digit index; the 3-bit width makes 7 roll over to 0 naturally.
    function automatic sel_t next_sel(input sel_t s);
        return s + 3'd1;
    endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// Free-running prescaler: tick is high for one cycle out of every DIV cycles.
import seg_pkg::*;

module seg_tick_gen #(
    parameter int DIV = REFRESH_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Tick is decoded from the count so it lines up with the wrap cycle itself.
    assign tick = (cnt == LAST);

    // Count 0..DIV-1 and wrap; restarting from 0 on reset gives a full first period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed digit scanner feeding the seven-segment decoder.
// Holds eight hex digits, steps sel every REFRESH_DIV cycles, flags frame start.
import seg_pkg::*;

module seg_scan_ctrl #(
    parameter int REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [2:0]            wr_addr,
    input  logic [3:0]            wr_data,
    input  logic [NUM_DIGITS-1:0] digit_en,
    output logic [2:0]            sel,
    output logic [3:0]            num,
    output logic                  blank,
    output logic                  frame_start
);

    localparam sel_t LAST_SEL = sel_t'(NUM_DIGITS - 1);

    logic                           step;
    logic [NUM_DIGITS-1:0][3:0]     digits;

    seg_tick_gen #(
        .DIV   (REFRESH_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (step)
    );

    // Host write port: one digit per cycle, no back-pressure, last write wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            digits <= '0;
        else if (wr_en)
            digits[wr_addr] <= wr_data;
    end

    // Advance the scan index on each step; flag the cycle sel lands on 0 after 7.
    // frame_start is derived from the pre-step sel so the first frame after
    // reset (which starts at 0 without a wrap) is not flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel         <= '0;
            frame_start <= 1'b0;
        end else begin
            if (step)
                sel <= next_sel(sel);
            frame_start <= step && (sel == LAST_SEL);
        end
    end

    // Combinational read so a write to the incoming digit shows up together with the new sel.
    assign num   = digits[sel];
    assign blank = ~digit_en[sel];

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: the driver predicts outputs from elapsed
// cycles since reset and a digit array model; a monitor pops and compares.
module tb_seg_scan_ctrl;

    localparam int RD    = 4;
    localparam int FRAME = 8 * RD;

    typedef struct {
        logic [2:0] sel;
        logic [3:0] num;
        logic       blank;
        logic       fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [7:0] digit_en;
    logic [2:0] sel;
    logic [3:0] num;
    logic       blank;
    logic       frame_start;

    exp_t       q[$];
    int         nvec = 0;
    int         nerr = 0;

    // reference state: edges since reset release, digit contents, pending write
    int         k = 0;
    logic [3:0] mdig[8];
    bit         p_wr   = 0;
    logic [2:0] p_addr = '0;
    logic [3:0] p_data = '0;

    seg_scan_ctrl #(.REFRESH_DIV(RD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .digit_en    (digit_en),
        .sel         (sel),
        .num         (num),
        .blank       (blank),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic int exp_sel(input int kk);
        return (kk / RD) % 8;
    endfunction

    function automatic void push_exp(input logic [7:0] den);
        exp_t e;
        int   s;
        s       = exp_sel(k);
        e.sel   = 3'(s);
        e.num   = mdig[s];
        e.blank = ~den[s];
        e.fs    = (k > 0) && (k % FRAME == 0);
        q.push_back(e);
    endfunction

    // One clock: account for the edge just taken, optionally reset/release, drive new inputs, predict.
    task automatic tick(input bit w, input logic [2:0] a, input logic [3:0] d,
                        input logic [7:0] den, input bit do_rst, input bit do_rel);
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (p_wr) mdig[p_addr] = p_data;
            k++;
        end
        if (do_rel) rst_n = 1'b1;
        if (do_rst) begin
            #1;
            rst_n = 1'b0;
            k = 0;
            for (int i = 0; i < 8; i++) mdig[i] = 4'h0;
        end
        wr_en    = w;
        wr_addr  = a;
        wr_data  = d;
        digit_en = den;
        p_wr     = w;
        p_addr   = a;
        p_data   = d;
        push_exp(den);
    endtask

    task automatic idle(input int n, input logic [7:0] den);
        for (int i = 0; i < n; i++) tick(0, 3'd0, 4'h0, den, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents a sel/num pair; compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            nvec++;
            if (q.size() == 0) begin
                nerr++;
                $display("FAIL vec %0d: no prediction queued (got sel=%0d num=%h)", nvec, sel, num);
            end else begin
                e = q.pop_front();
                if (sel !== e.sel || num !== e.num || blank !== e.blank || frame_start !== e.fs) begin
                    nerr++;
                    $display("FAIL vec %0d @%0t: got sel=%0d num=%h blank=%b fs=%b, expected sel=%0d num=%h blank=%b fs=%b",
                             nvec, $time, sel, num, blank, frame_start, e.sel, e.num, e.blank, e.fs);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] den;
        rst_n    = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        digit_en = 8'hFF;
        for (int i = 0; i < 8; i++) mdig[i] = 4'h0;
        #1 rst_n = 1'b0;

        // reset held, then released mid-cycle
        idle(2, 8'hFF);
        tick(0, 3'd0, 4'h0, 8'hFF, 0, 1);

        // free scan, no writes: two full frames plus a bit
        idle(2 * FRAME + 6, 8'hFF);

        // load digit i with i+8, then watch a frame
        for (int i = 0; i < 8; i++) tick(1, 3'(i), 4'(i + 8), 8'hFF, 0, 0);
        idle(FRAME + 2, 8'hFF);

        // write 5 to the current digit mid-dwell
        for (int n = 0; n < RD && (k % RD) != 1; n++) idle(1, 8'hFF);
        tick(1, 3'(exp_sel(k)), 4'h5, 8'hFF, 0, 0);
        idle(3, 8'hFF);

        // write the next digit on the same edge that steps sel
        for (int n = 0; n < RD && ((k + 1) % RD) != 0; n++) idle(1, 8'hFF);
        tick(1, 3'(exp_sel(k + 1)), 4'hC, 8'hFF, 0, 0);
        idle(3, 8'hFF);

        // back-to-back writes to one address: last wins
        tick(1, 3'd6, 4'h1, 8'hFF, 0, 0);
        tick(1, 3'd6, 4'h2, 8'hFF, 0, 0);
        idle(2, 8'hFF);

        // partial blanking over a full frame
        idle(FRAME + 2, 8'b1111_0101);

        // randomized writes with occasionally changing enables
        den = 8'hFF;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) den = 8'($urandom);
            tick(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 4'($urandom_range(0, 15)), den, 0, 0);
        end

        // asynchronous reset at sel=5, cnt=2, held one cycle, then a full frame
        for (int n = 0; n < FRAME && ((k + 1) % FRAME) != 22; n++) idle(1, 8'hFF);
        tick(0, 3'd0, 4'h0, 8'hFF, 1, 0);
        tick(1, 3'd2, 4'h9, 8'hFF, 0, 1);
        idle(FRAME + 4, 8'hFF);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            nerr++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
